// File: rtl/rbm_hidden_sampler.sv
// ---------------------------------------------------------------------------
// rbm_hidden_sampler
//
// Runs the hidden-layer sampling of a restricted Boltzmann machine. For each
// hidden unit j it walks all visible units and accumulates the Q4.4 weights
// whose visible bit is set into a saturating Q8.4 sum. That sum drives an
// external combinational sigmoid. The sigmoid output is then compared with a
// random byte to draw a spike. The whole sweep repeats ITERATIONS times. The
// per-unit spike counts are then streamed out over a valid/ready interface.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   start          one-cycle request, only honoured while idle
//   busy, done     busy outside IDLE; done pulses once after the last score
//   v_addr, w_addr visible / weight read addresses (w_addr = j*NUM_VISIBLE+i)
//   mem_en         read strobe; v_data / w_data arrive one cycle later
//   v_data, w_data visible bit and signed Q4.4 weight
//   sig_sum        registered Q8.4 sum feeding the sigmoid
//   sig_s          sigmoid output (Q0.8, combinational from sig_sum)
//   rnd_req, rnd   RNG advance strobe and the current random byte
//   score_valid/score_ready/score_idx/score  spike-count output stream
// ---------------------------------------------------------------------------
module rbm_hidden_sampler #(
    parameter int BITN        = 8,
    parameter int SUM_BITN    = 12,
    parameter int NUM_VISIBLE = 784,
    parameter int NUM_HIDDEN  = 10,
    parameter int ITERATIONS  = 100,
    parameter int SCORE_BITN  = $clog2(ITERATIONS + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    output logic                                     busy,
    output logic                                     done,
    output logic [$clog2(NUM_VISIBLE)-1:0]           v_addr,
    output logic [$clog2(NUM_VISIBLE*NUM_HIDDEN)-1:0] w_addr,
    output logic                                     mem_en,
    input  logic                                     v_data,
    input  logic [BITN-1:0]                          w_data,
    output logic [SUM_BITN-1:0]                      sig_sum,
    input  logic [BITN-1:0]                          sig_s,
    output logic                                     rnd_req,
    input  logic [BITN-1:0]                          rnd,
    output logic                                     score_valid,
    input  logic                                     score_ready,
    output logic [$clog2(NUM_HIDDEN)-1:0]            score_idx,
    output logic [SCORE_BITN-1:0]                    score
);

    localparam int VA_W = $clog2(NUM_VISIBLE);
    localparam int WA_W = $clog2(NUM_VISIBLE * NUM_HIDDEN);
    localparam int HJ_W = $clog2(NUM_HIDDEN);

    localparam logic [VA_W-1:0]       LAST_VIS = VA_W'(NUM_VISIBLE - 1);
    localparam logic [HJ_W-1:0]       LAST_HID = HJ_W'(NUM_HIDDEN - 1);
    localparam logic [SCORE_BITN-1:0] LAST_IT  = SCORE_BITN'(ITERATIONS - 1);
    localparam logic [SUM_BITN-1:0]   SUM_MAX  = {1'b0, {(SUM_BITN-1){1'b1}}};
    localparam logic [SUM_BITN-1:0]   SUM_MIN  = {1'b1, {(SUM_BITN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, CLEAR, ACCUM, DRAIN, SIG, SAMPLE, OUTPUT, DONE
    } state_t;

    state_t                state, next_state;
    logic [VA_W-1:0]       i;
    logic [HJ_W-1:0]       j;
    logic [SCORE_BITN-1:0] it;
    logic [SUM_BITN-1:0]   acc, acc_next;
    logic [SUM_BITN:0]     term, wide_sum;
    logic                  data_valid;
    logic                  spike;
    logic [SCORE_BITN-1:0] counter [NUM_HIDDEN];

    // State register. Reset from any state returns to IDLE, dropping the pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. One hidden unit takes ACCUM (NUM_VISIBLE cycles)
    // followed by DRAIN, SIG and SAMPLE. SAMPLE then either starts the next
    // unit / iteration or moves on to streaming out the scores.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = ACCUM;
            ACCUM:   if (i == LAST_VIS) next_state = DRAIN;
            DRAIN:   next_state = SIG;
            SIG:     next_state = SAMPLE;
            SAMPLE:  if (j != LAST_HID || it != LAST_IT) next_state = ACCUM;
                     else next_state = OUTPUT;
            OUTPUT:  if (score_ready && j == LAST_HID) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Saturating accumulate of the term that arrives one cycle after the
    // read strobe. The sum is widened by one bit so that overflow shows up
    // as a disagreement between the top two bits and can be clamped.
    // data_valid is low in the first ACCUM cycle, because no read is in
    // flight then, so acc holds its cleared value for that cycle.
    always_comb begin
        term     = v_data ? {{(SUM_BITN + 1 - BITN){w_data[BITN-1]}}, w_data} : '0;
        wide_sum = {acc[SUM_BITN-1], acc} + term;
        acc_next = acc;
        if (data_valid) begin
            if (wide_sum[SUM_BITN] != wide_sum[SUM_BITN-1]) begin
                acc_next = wide_sum[SUM_BITN] ? SUM_MIN : SUM_MAX;
            end else begin
                acc_next = wide_sum[SUM_BITN-1:0];
            end
        end
    end

    // Datapath registers: the visible / hidden / iteration indices, the
    // accumulator, the sigmoid input register and the spike counters.
    // acc is cleared in the cycle before every ACCUM entry (CLEAR or SAMPLE).
    // The last iteration's SAMPLE leaves j at 0, ready for the output stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i          <= '0;
            j          <= '0;
            it         <= '0;
            acc        <= '0;
            sig_sum    <= '0;
            data_valid <= 1'b0;
            for (int h = 0; h < NUM_HIDDEN; h++) counter[h] <= '0;
        end else begin
            data_valid <= (state == ACCUM);
            case (state)
                CLEAR: begin
                    i   <= '0;
                    j   <= '0;
                    it  <= '0;
                    acc <= '0;
                    for (int h = 0; h < NUM_HIDDEN; h++) counter[h] <= '0;
                end
                ACCUM: begin
                    acc <= acc_next;
                    i   <= (i == LAST_VIS) ? '0 : i + 1'b1;
                end
                DRAIN: begin
                    acc     <= acc_next;
                    sig_sum <= acc_next;
                end
                SAMPLE: begin
                    acc        <= '0;
                    counter[j] <= counter[j] + SCORE_BITN'(spike);
                    if (j != LAST_HID) begin
                        j <= j + 1'b1;
                    end else begin
                        j <= '0;
                        if (it != LAST_IT) it <= it + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (score_ready) j <= (j == LAST_HID) ? '0 : j + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output decode from the state and the index registers. Because the state
    // register resets to IDLE, every strobe drops in the same cycle as rst.
    // A spike needs the sigmoid strictly above the random byte.
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        mem_en      = (state == ACCUM);
        rnd_req     = (state == SAMPLE);
        score_valid = (state == OUTPUT);
        spike       = (sig_s > rnd);
        v_addr      = i;
        w_addr      = WA_W'(j) * WA_W'(NUM_VISIBLE) + WA_W'(i);
        score_idx   = score_valid ? j : '0;
        score       = score_valid ? counter[j] : '0;
    end

endmodule

// File: tb/tb_rbm_hidden_sampler.sv
// ---------------------------------------------------------------------------
// tb_rbm_hidden_sampler
//
// Directed bench for rbm_hidden_sampler. It uses two instances:
//   dut_a: NUM_VISIBLE=4, NUM_HIDDEN=2, ITERATIONS=3 for timing, spike,
//          masking, backpressure and reset/start behaviour.
//   dut_b: NUM_VISIBLE=20, NUM_HIDDEN=2, ITERATIONS=1 for sum saturation.
// The memories are registered one-cycle models. The sigmoid model returns
// 0x40 for a zero sum, 0xC0 for a positive sum and 0x20 for a negative sum.
// ---------------------------------------------------------------------------
module tb_rbm_hidden_sampler;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_start, a_busy, a_done, a_mem_en, a_v_data, a_rnd_req;
    logic        a_score_valid, a_ready;
    logic [1:0]  a_v_addr;
    logic [2:0]  a_w_addr;
    logic [7:0]  a_w_data, a_sig_s, a_rnd;
    logic [11:0] a_sig_sum;
    logic [0:0]  a_score_idx;
    logic [1:0]  a_score;

    logic        b_start, b_busy, b_done, b_mem_en, b_v_data, b_rnd_req;
    logic        b_score_valid, b_ready;
    logic [4:0]  b_v_addr;
    logic [5:0]  b_w_addr;
    logic [7:0]  b_w_data, b_sig_s, b_rnd;
    logic [11:0] b_sig_sum;
    logic [0:0]  b_score_idx;
    logic [0:0]  b_score;

    logic        v_mem_a [4];
    logic [7:0]  w_mem_a [8];
    logic        v_mem_b [20];
    logic [7:0]  w_mem_b [40];

    int          compared   = 0;
    int          mismatched = 0;

    logic [11:0] sums [16];
    int          memen_per_unit [16];
    logic [2:0]  waddr_log [32];
    int          hs_idx [8];
    int          hs_score [8];
    int          n_sums, n_hs, n_done, done_at, n_memen;

    logic [11:0] b_sums [4];
    int          b_hs_score [4];
    int          b_n_sums, b_n_hs;

    always #5 clk = ~clk;

    // Registered memory models: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (a_mem_en) begin
            a_v_data <= v_mem_a[a_v_addr];
            a_w_data <= w_mem_a[a_w_addr];
        end
        if (b_mem_en) begin
            b_v_data <= v_mem_b[b_v_addr];
            b_w_data <= w_mem_b[b_w_addr];
        end
    end

    function automatic logic [7:0] sig_model(input logic [11:0] s);
        if (s == 12'h000) return 8'h40;
        else if (!s[11]) return 8'hC0;
        else return 8'h20;
    endfunction

    assign a_sig_s = sig_model(a_sig_sum);
    assign b_sig_s = sig_model(b_sig_sum);

    rbm_hidden_sampler #(
        .BITN(8), .SUM_BITN(12), .NUM_VISIBLE(4), .NUM_HIDDEN(2), .ITERATIONS(3)
    ) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .v_addr(a_v_addr), .w_addr(a_w_addr), .mem_en(a_mem_en),
        .v_data(a_v_data), .w_data(a_w_data), .sig_sum(a_sig_sum),
        .sig_s(a_sig_s), .rnd_req(a_rnd_req), .rnd(a_rnd),
        .score_valid(a_score_valid), .score_ready(a_ready),
        .score_idx(a_score_idx), .score(a_score)
    );

    rbm_hidden_sampler #(
        .BITN(8), .SUM_BITN(12), .NUM_VISIBLE(20), .NUM_HIDDEN(2), .ITERATIONS(1)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .v_addr(b_v_addr), .w_addr(b_w_addr), .mem_en(b_mem_en),
        .v_data(b_v_data), .w_data(b_w_data), .sig_sum(b_sig_sum),
        .sig_s(b_sig_s), .rnd_req(b_rnd_req), .rnd(b_rnd),
        .score_valid(b_score_valid), .score_ready(b_ready),
        .score_idx(b_score_idx), .score(b_score)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one pass on dut_a. It pulses start and then watches every negedge.
    // t counts the clock edges after the start edge. hold_low keeps
    // score_ready low for that many OUTPUT cycles. poke_at pulses start
    // again at cycle t, and reset_at asserts rst at cycle t and aborts.
    // A negative value disables poke_at or reset_at.
    task automatic applyStimulus(input int hold_low, input int poke_at, input int reset_at);
        int  hold;
        int  run_memen;
        bit  bp_seen;
        bit  did_reset;
        n_sums = 0; n_hs = 0; n_done = 0; done_at = -1; n_memen = 0;
        hold = 0; run_memen = 0; bp_seen = 0; did_reset = 0;
        a_ready = (hold_low == 0);
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int t = 0; t < 300; t++) begin
            a_start = (t == poke_at);
            if (t == reset_at) begin
                checkOutput("pre_reset_sig_sum", 32'(a_sig_sum), 32'h030);
                checkOutput("pre_reset_mem_en", 32'(a_mem_en), 32'h1);
                rst = 1'b1;
                #1;
                checkOutput("mid_reset_outputs",
                            32'({a_busy, a_done, a_mem_en, a_rnd_req, a_score_valid,
                                 a_sig_sum, a_v_addr, a_w_addr, a_score_idx, a_score}), 32'h0);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                checkOutput("post_reset_idle",
                            32'({a_busy, a_done, a_mem_en, a_rnd_req, a_score_valid}), 32'h0);
                did_reset = 1;
                break;
            end
            if (a_mem_en) begin
                if (n_memen < 32) waddr_log[n_memen] = a_w_addr;
                n_memen++;
                run_memen++;
            end
            if (a_rnd_req) begin
                if (n_sums < 16) begin
                    sums[n_sums] = a_sig_sum;
                    memen_per_unit[n_sums] = run_memen;
                end
                n_sums++;
                run_memen = 0;
            end
            if (a_score_valid) bp_seen = 1;
            if (bp_seen && hold < hold_low) begin
                checkOutput("bp_valid", 32'(a_score_valid), 32'h1);
                checkOutput("bp_idx", 32'(a_score_idx), 32'h0);
                checkOutput("bp_score", 32'(a_score), 32'h3);
                hold++;
            end else if (bp_seen) begin
                a_ready = 1'b1;
            end
            if (a_score_valid && a_ready) begin
                if (n_hs < 8) begin
                    hs_idx[n_hs] = int'(a_score_idx);
                    hs_score[n_hs] = int'(a_score);
                end
                n_hs++;
            end
            if (a_done) begin
                n_done++;
                if (done_at < 0) done_at = t;
            end
            if (done_at >= 0 && t >= done_at + 3) break;
            @(negedge clk);
        end
        a_start = 1'b0;
        if (!did_reset) checkOutput("done_seen", 32'(done_at >= 0), 32'h1);
    endtask

    task automatic checkRun(input string pfx, input int s0, input int s1, input int exp_done);
        checkOutput({pfx, "_n_hs"}, 32'(n_hs), 32'(2));
        checkOutput({pfx, "_idx0"}, 32'(hs_idx[0]), 32'(0));
        checkOutput({pfx, "_score0"}, 32'(hs_score[0]), 32'(s0));
        checkOutput({pfx, "_idx1"}, 32'(hs_idx[1]), 32'(1));
        checkOutput({pfx, "_score1"}, 32'(hs_score[1]), 32'(s1));
        checkOutput({pfx, "_n_done"}, 32'(n_done), 32'(1));
        checkOutput({pfx, "_done_at"}, 32'(done_at), 32'(exp_done));
    endtask

    // Runs one pass on dut_b and collects the sample sums and the scores.
    task automatic runB();
        int b_done_at;
        b_n_sums = 0; b_n_hs = 0; b_done_at = -1;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (b_rnd_req) begin
                if (b_n_sums < 4) b_sums[b_n_sums] = b_sig_sum;
                b_n_sums++;
            end
            if (b_score_valid && b_ready) begin
                if (b_n_hs < 4) b_hs_score[b_n_hs] = int'(b_score) + int'(b_score_idx) * 0;
                b_n_hs++;
            end
            if (b_done) begin
                b_done_at = t;
                break;
            end
            @(negedge clk);
        end
        checkOutput("b_done_seen", 32'(b_done_at >= 0), 32'h1);
        checkOutput("b_n_sums", 32'(b_n_sums), 32'(2));
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1;
        a_rnd = 8'h30; b_rnd = 8'h30;
        for (int k = 0; k < 4; k++) v_mem_a[k] = 1'b1;
        for (int k = 0; k < 8; k++) w_mem_a[k] = 8'h00;
        for (int k = 0; k < 20; k++) v_mem_b[k] = 1'b1;
        for (int k = 0; k < 40; k++) w_mem_b[k] = 8'h7F;
        repeat (3) @(negedge clk);
        checkOutput("reset_a_outputs",
                    32'({a_busy, a_done, a_mem_en, a_rnd_req, a_score_valid,
                         a_sig_sum, a_v_addr, a_w_addr, a_score_idx, a_score}), 32'h0);
        checkOutput("reset_b_busy", 32'(b_busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Zero weights: the sum is 0 and the sigmoid gives 0x40 > 0x30, so every sample spikes.
        applyStimulus(0, -1, -1);
        checkOutput("s1_n_sums", 32'(n_sums), 32'(6));
        for (int k = 0; k < 6; k++) checkOutput($sformatf("s1_sum%0d", k), 32'(sums[k]), 32'h000);
        checkOutput("s1_memen_total", 32'(n_memen), 32'(24));
        checkRun("s1", 3, 3, 45);

        // Equal sigmoid and random byte: no spike.
        a_rnd = 8'h40;
        applyStimulus(0, -1, -1);
        checkRun("s2", 0, 0, 45);
        a_rnd = 8'h30;

        // Visible masking: unit 1 sums only 0x10 + 0x20.
        v_mem_a[0] = 1'b1; v_mem_a[1] = 1'b0; v_mem_a[2] = 1'b1; v_mem_a[3] = 1'b0;
        w_mem_a[4] = 8'h10; w_mem_a[5] = 8'h70; w_mem_a[6] = 8'h20; w_mem_a[7] = 8'h70;
        applyStimulus(0, -1, -1);
        checkOutput("s4_sum_j0", 32'(sums[0]), 32'h000);
        checkOutput("s4_sum_j1", 32'(sums[1]), 32'h030);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("s4_waddr%0d", k + 4), 32'(waddr_log[k + 4]), 32'(k + 4));
        checkOutput("s4_memen_u0", 32'(memen_per_unit[0]), 32'(4));
        checkOutput("s4_memen_u1", 32'(memen_per_unit[1]), 32'(4));
        checkRun("s4", 3, 3, 45);

        // Backpressure: five stalled OUTPUT cycles delay done by five.
        applyStimulus(5, -1, -1);
        checkRun("s5", 3, 3, 50);

        // A start pulse in the middle of ACCUM is ignored.
        applyStimulus(0, 3, -1);
        checkRun("s6a", 3, 3, 45);

        // Reset mid-ACCUM (iteration 1, unit 0), then a clean rerun.
        applyStimulus(0, -1, 16);
        applyStimulus(0, -1, -1);
        checkOutput("s6b_sum_j1", 32'(sums[1]), 32'h030);
        checkRun("s6b", 3, 3, 45);

        // Saturation on dut_b: 20 * 0x7F clamps to 0x7FF, and 20 * 0x80 clamps to 0x800.
        runB();
        checkOutput("s3_pos_sum0", 32'(b_sums[0]), 32'h7FF);
        checkOutput("s3_pos_sum1", 32'(b_sums[1]), 32'h7FF);
        checkOutput("s3_pos_score0", 32'(b_hs_score[0]), 32'(1));
        for (int k = 0; k < 40; k++) w_mem_b[k] = 8'h80;
        runB();
        checkOutput("s3_neg_sum0", 32'(b_sums[0]), 32'h800);
        checkOutput("s3_neg_sum1", 32'(b_sums[1]), 32'h800);
        checkOutput("s3_neg_score0", 32'(b_hs_score[0]), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
